// File: rtl/data_compare_seq_if.sv
// Request/result bus for data_compare_seq.
// The slave modport is the comparator side; the master modport is the requester/consumer side.
interface data_compare_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 3
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       iData;
  logic             oValid;
  logic             iReady;
  logic [2:0]       oData;
  logic [CNTW-1:0]  oCnt;

  modport slave (
    input  iValid, iData_a, iData_b, iData, iReady,
    output oReady, oValid, oData, oCnt
  );

  modport master (
    output iValid, iData_a, iData_b, iData, iReady,
    input  oReady, oValid, oData, oCnt
  );
endinterface

// File: rtl/data_compare_seq.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands one
// SLICE-bit slice per clock, MSB slice first, stopping at the first unequal
// slice. Equal operands pass the captured cascade value {gt,lt,eq} through.
// Optional feature: define SIGNED_CMP_EN to treat the operands as two's
// complement (only the MSB slice is compared signed).
module data_compare_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic               iClk,
  input  logic               iRst_n,
  data_compare_seq_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNTW   = $clog2(NSLICE) + 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NSLICE - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(NSLICE);

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_check
    $error("data_compare_seq: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       casc_q;
  logic [IDXW-1:0]  idx;
  logic             ready_q;
  logic             valid_q;
  logic [2:0]       data_q;
  logic [CNTW-1:0]  cnt_q;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_gt;
  logic             slice_lt;

  // Extract and compare the slice at the current index.
  always_comb begin
    slice_a  = a_q[int'(idx) * SLICE +: SLICE];
    slice_b  = b_q[int'(idx) * SLICE +: SLICE];
`ifdef SIGNED_CMP_EN
    if (idx == LAST_IDX) begin
      slice_gt = $signed(slice_a) > $signed(slice_b);
      slice_lt = $signed(slice_a) < $signed(slice_b);
    end else begin
      slice_gt = slice_a > slice_b;
      slice_lt = slice_a < slice_b;
    end
`else
    slice_gt = slice_a > slice_b;
    slice_lt = slice_a < slice_b;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      idx     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // oReady comes up one edge after reset release, so the first
          // accept can only happen on the edge after that.
          if (bus.iValid && ready_q) begin
            a_q     <= bus.iData_a;
            b_q     <= bus.iData_b;
            casc_q  <= bus.iData;
            idx     <= LAST_IDX;
            ready_q <= 1'b0;
            state   <= CMP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CMP: begin
          if (slice_gt || slice_lt) begin
            data_q  <= slice_gt ? 3'b100 : 3'b010;
            cnt_q   <= FULL_CNT - CNTW'(idx);
            valid_q <= 1'b1;
            state   <= DONE;
          end else if (idx != '0) begin
            idx <= idx - 1'b1;
          end else begin
            data_q  <= casc_q;
            cnt_q   <= FULL_CNT;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.iReady) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReady = ready_q;
  assign bus.oValid = valid_q;
  assign bus.oData  = data_q;
  assign bus.oCnt   = cnt_q;

endmodule

// File: tb/tb_data_compare_seq.sv
// Directed self-checking bench for data_compare_seq (WIDTH=16, SLICE=4).
// Honours SIGNED_CMP_EN for the signed-operand vector.
module tb_data_compare_seq;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNTW   = $clog2(NSLICE) + 1;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  data_compare_seq_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  data_compare_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Wait for oReady, present one request, then scramble the inputs after the
  // accept edge. Returns the number of edges until oValid (0 on timeout).
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] casc, output int lat);
    int n;
    n = 0;
    while (bus.oReady !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("ready_before_req", 32'(bus.oReady), 32'd1);
    bus.iValid  = 1'b1;
    bus.iData_a = a;
    bus.iData_b = b;
    bus.iData   = casc;
    tick();
    bus.iValid  = 1'b0;
    bus.iData_a = ~a;
    bus.iData_b = a;
    bus.iData   = ~casc;
    lat = 0;
    for (int i = 1; i <= NSLICE + 4; i++) begin
      tick();
      if (bus.oValid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic ack();
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
    check("ack_valid_low", 32'(bus.oValid), 32'd0);
    check("ack_ready_high", 32'(bus.oReady), 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] casc, input logic [2:0] exp_data,
                         input int exp_cnt);
    int lat;
    issue(a, b, casc, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_cnt));
    check({tag, "_data"}, 32'(bus.oData), 32'(exp_data));
    check({tag, "_cnt"}, 32'(bus.oCnt), 32'(exp_cnt));
    ack();
  endtask

  initial begin
    int lat;
    bit saw_valid;
    logic [2:0] signed_exp;

    bus.iValid  = 1'b0;
    bus.iReady  = 1'b0;
    bus.iData_a = '0;
    bus.iData_b = '0;
    bus.iData   = '0;

    // Reset state and oReady rising on the first edge after release.
    #2 iRst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.oReady), 32'd0);
    check("rst_valid", 32'(bus.oValid), 32'd0);
    check("rst_data", 32'(bus.oData), 32'd0);
    check("rst_cnt", 32'(bus.oCnt), 32'd0);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    check("post_rst_ready_low", 32'(bus.oReady), 32'd0);
    tick();
    check("post_rst_ready_high", 32'(bus.oReady), 32'd1);

    // Main function: early exit, each slice position, cascade passthrough.
    run_vec("msb_gt",   16'hA000, 16'h5000, 3'b000, 3'b100, 1);
    run_vec("lsb_lt",   16'h1235, 16'h1236, 3'b000, 3'b010, 4);
    run_vec("s2_lt",    16'h1205, 16'h1305, 3'b001, 3'b010, 2);
    run_vec("s1_gt",    16'h12F5, 16'h1235, 3'b001, 3'b100, 3);
    run_vec("eq_c010",  16'hC3C3, 16'hC3C3, 3'b010, 3'b010, 4);
    run_vec("eq_c001",  16'hC3C3, 16'hC3C3, 3'b001, 3'b001, 4);
    run_vec("eq_c111",  16'hFFFF, 16'hFFFF, 3'b111, 3'b111, 4);

`ifdef SIGNED_CMP_EN
    signed_exp = 3'b010;
`else
    signed_exp = 3'b100;
`endif
    run_vec("sign_msb", 16'h8000, 16'h7FFF, 3'b000, signed_exp, 1);

    // Result held under backpressure while iValid is pulsed with new data.
    issue(16'hA000, 16'h5000, 3'b000, lat);
    check("hold_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.iValid  = 1'b1;
      bus.iData_a = 16'h0001;
      bus.iData_b = 16'hFFFF;
      bus.iData   = 3'b001;
      tick();
      check("hold_valid", 32'(bus.oValid), 32'd1);
      check("hold_data", 32'(bus.oData), 32'b100);
      check("hold_cnt", 32'(bus.oCnt), 32'd1);
      check("hold_ready", 32'(bus.oReady), 32'd0);
    end
    bus.iValid = 1'b0;
    ack();
    tick();
    check("hold_no_capture", 32'(bus.oValid), 32'd0);
    check("hold_idle_data", 32'(bus.oData), 32'b100);

    // Reset in the middle of a comparison aborts it with no result.
    bus.iValid  = 1'b1;
    bus.iData_a = 16'h1235;
    bus.iData_b = 16'h1236;
    bus.iData   = 3'b000;
    tick();
    bus.iValid = 1'b0;
    tick();
    iRst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.oValid), 32'd0);
    check("abort_data", 32'(bus.oData), 32'd0);
    check("abort_cnt", 32'(bus.oCnt), 32'd0);
    check("abort_ready", 32'(bus.oReady), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.oValid === 1'b1) saw_valid = 1'b1;
    end
    check("abort_no_result", 32'(saw_valid), 32'd0);

    // Normal operation resumes after the abort.
    run_vec("post_abort", 16'h0010, 16'h0001, 3'b000, 3'b100, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
